// File: rtl/i2c_counter_slave.sv
// -----------------------------------------------------------------------------
// i2c_counter_slave
//
// I2C slave that gives a bus master read access to NUM_CH counters of
// CNT_WIDTH bits each, and write access to one command/pointer byte.
//
// The master writes one byte after a write address. That byte becomes CMD,
// and it also sets the read pointer when it is a valid byte index.
// A read address takes an atomic snapshot of CNTR. Snapshot bytes are then
// streamed from the pointer: channel 0 first, each channel MSB byte first.
// The pointer auto-increments and wraps after every byte read.
// Repeated START and NACK-terminated reads are supported.
//
// Ports
//   CLCK       in   system clock; every flop is on its rising edge
//   RST        in   asynchronous, active-high reset
//   SCL        in   I2C clock from the bus (asynchronous to CLCK)
//   SDA        io   I2C data; only ever driven low or released (z)
//   CNTR       in   NUM_CH*CNT_WIDTH flattened counters, channel 0 in LSBs
//   CMD        out  last command byte written by the master
//   CMD_VALID  out  one-CLCK pulse when CMD updates
//   TEND       out  one-CLCK pulse on STOP ending an addressed transaction
//   BUSY       out  high from address-match ACK until STOP
//
// Parameter ranges: NUM_CH 1..16; CNT_WIDTH a multiple of 8 in 8..32.
// CLCK must run at least 16x SCL. There is no clock stretching.
// -----------------------------------------------------------------------------
module i2c_counter_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1110010,
   parameter int         NUM_CH     = 4,
   parameter int         CNT_WIDTH  = 16
) (
   input  logic                        CLCK,
   input  logic                        RST,
   input  logic                        SCL,
   inout  wire                         SDA,
   input  logic [NUM_CH*CNT_WIDTH-1:0] CNTR,
   output logic [7:0]                  CMD,
   output logic                        CMD_VALID,
   output logic                        TEND,
   output logic                        BUSY
);

   localparam int NUM_BYTES = NUM_CH * CNT_WIDTH / 8;
   localparam int BPC       = CNT_WIDTH / 8;   // bytes per channel
   localparam int PTR_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int SNAP_W    = NUM_CH * CNT_WIDTH;

   localparam logic [8:0]       NB_LIM   = 9'(NUM_BYTES);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } state_t;

   // Synchronisers: two metastability flops plus one history flop per line.
   logic [1:0] scl_sync_q;
   logic       scl_hist_q;
   logic [1:0] sda_sync_q;
   logic       sda_hist_q;

   // Protocol state
   state_t           state_q,     state_d;
   logic [3:0]       bit_cnt_q,   bit_cnt_d;
   logic [6:0]       shift_q,     shift_d;
   logic             rw_q,        rw_d;
   logic             first_wr_q,  first_wr_d;
   logic             ack_phase_q, ack_phase_d;
   logic [PTR_W-1:0] ptr_q,       ptr_d;
   logic [SNAP_W-1:0] snap_q,     snap_d;
   logic [7:0]       cmd_q,       cmd_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             tend_q,      tend_d;
   logic             busy_q,      busy_d;
   logic             sda_oe_q,    sda_oe_d;

   // Bus conditions derived from the synchronised lines
   logic       scl_s;
   logic       sda_s;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic [7:0] rx_byte;
   logic [7:0] rd_byte;
   logic [PTR_W-1:0] ptr_inc;

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  =  scl_s & ~scl_hist_q;
   assign scl_fall  = ~scl_s &  scl_hist_q;
   assign start_det =  scl_s &  sda_hist_q & ~sda_s;
   assign stop_det  =  scl_s & ~sda_hist_q &  sda_s;

   // Byte as it will stand once the bit currently on SDA is shifted in.
   assign rx_byte = {shift_q, sda_s};

   assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);

   // Re-order the flattened snapshot into the byte stream seen by the master.
   // Byte index k is channel k/BPC, byte (k%BPC) counted from that channel's MSB.
   logic [7:0] snap_bytes [NUM_BYTES];

   for (genvar g = 0; g < NUM_BYTES; g++) begin : g_snap_bytes
      localparam int CH = g / BPC;
      localparam int BI = g % BPC;
      assign snap_bytes[g] = snap_q[CH*CNT_WIDTH + (BPC-1-BI)*8 +: 8];
   end

   assign rd_byte = snap_bytes[ptr_q];

   // Open-drain data line
   assign SDA = sda_oe_q ? 1'b0 : 1'bz;

   assign CMD       = cmd_q;
   assign CMD_VALID = cmd_valid_q;
   assign TEND      = tend_q;
   assign BUSY      = busy_q;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rw_d        = rw_q;
      first_wr_d  = first_wr_q;
      ack_phase_d = ack_phase_q;
      ptr_d       = ptr_q;
      snap_d      = snap_q;
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      tend_d      = 1'b0;
      busy_d      = busy_q;
      sda_oe_d    = sda_oe_q;

      if (stop_det) begin
         // STOP ends everything. TEND marks only transactions that were addressed.
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         tend_d   = busy_q;
         busy_d   = 1'b0;
      end else if (start_det) begin
         // Plain or repeated START; BUSY is kept until the real STOP.
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
            end

            ADDR: begin
               if (scl_rise) begin
                  shift_d   = rx_byte[6:0];
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (rx_byte[7:1] == SLAVE_ADDR) begin
                        state_d     = ADDR_ACK;
                        rw_d        = rx_byte[0];
                        ack_phase_d = 1'b0;
                     end else begin
                        state_d = IGNORE;
                     end
                  end
               end
            end

            // Two SCL falls: the first opens the ACK bit, the second closes it.
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase_q) begin
                     ack_phase_d = 1'b1;
                     sda_oe_d    = 1'b1;
                     busy_d      = 1'b1;
                     if (rw_q) begin
                        snap_d = CNTR;
                     end
                  end else begin
                     bit_cnt_d = 4'd0;
                     if (rw_q) begin
                        // The MSB of the first read byte goes out on this same fall.
                        state_d  = RD_DATA;
                        sda_oe_d = ~rd_byte[7];
                     end else begin
                        state_d    = WR_DATA;
                        sda_oe_d   = 1'b0;
                        first_wr_d = 1'b1;
                     end
                  end
               end
            end

            WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = rx_byte[6:0];
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     state_d     = WR_ACK;
                     ack_phase_d = 1'b0;
                     // Only the first byte after the address is a command.
                     if (first_wr_q) begin
                        first_wr_d  = 1'b0;
                        cmd_d       = rx_byte;
                        cmd_valid_d = 1'b1;
                        ptr_d       = ({1'b0, rx_byte} < NB_LIM) ? rx_byte[PTR_W-1:0] : '0;
                     end
                  end
               end
            end

            WR_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase_q) begin
                     ack_phase_d = 1'b1;
                     sda_oe_d    = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     state_d   = WR_DATA;
                     bit_cnt_d = 4'd0;
                  end
               end
            end

            // bit_cnt counts bits already clocked out. Each fall presents the next bit.
            RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = RD_ACK;
                  end else begin
                     sda_oe_d = ~rd_byte[3'd7 - bit_cnt_q[2:0]];
                  end
               end
            end

            RD_ACK: begin
               if (scl_rise) begin
                  ptr_d = ptr_inc;
                  if (sda_s) begin
                     state_d  = IGNORE;
                     sda_oe_d = 1'b0;
                  end else begin
                     state_d   = RD_DATA;
                     bit_cnt_d = 4'd0;
                  end
               end
            end

            IGNORE: begin
            end

            default: begin
               state_d  = IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLCK or posedge RST) begin
      if (RST) begin
         // Synchronisers reset to the idle-bus level so no false START/STOP appears.
         scl_sync_q  <= 2'b11;
         scl_hist_q  <= 1'b1;
         sda_sync_q  <= 2'b11;
         sda_hist_q  <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 7'd0;
         rw_q        <= 1'b0;
         first_wr_q  <= 1'b0;
         ack_phase_q <= 1'b0;
         ptr_q       <= '0;
         snap_q      <= '0;
         cmd_q       <= 8'd0;
         cmd_valid_q <= 1'b0;
         tend_q      <= 1'b0;
         busy_q      <= 1'b0;
         sda_oe_q    <= 1'b0;
      end else begin
         scl_sync_q  <= {scl_sync_q[0], SCL};
         scl_hist_q  <= scl_sync_q[1];
         sda_sync_q  <= {sda_sync_q[0], SDA};
         sda_hist_q  <= sda_sync_q[1];
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rw_q        <= rw_d;
         first_wr_q  <= first_wr_d;
         ack_phase_q <= ack_phase_d;
         ptr_q       <= ptr_d;
         snap_q      <= snap_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         tend_q      <= tend_d;
         busy_q      <= busy_d;
         sda_oe_q    <= sda_oe_d;
      end
   end

endmodule

// File: tb/tb_i2c_counter_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_counter_slave
//
// Directed bench for i2c_counter_slave with its default parameters.
// A bit-banged master drives SCL and SDA. Expected read bytes are queued
// before each read and popped as the bytes arrive. Pulses on CMD_VALID and
// TEND are counted by a monitor.
// -----------------------------------------------------------------------------
module tb_i2c_counter_slave;

   localparam int Q = 8;   // CLCK cycles per quarter SCL period

   logic        clk = 1'b0;
   logic        rst;
   logic        scl;
   logic        sda_m;
   logic [63:0] cntr;
   wire         sda_w;
   logic [7:0]  cmd;
   logic        cmd_valid;
   logic        tend;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cv_cnt   = 0;
   int tend_cnt = 0;

   logic [7:0] exp_q [$];

   pullup (sda_w);
   assign sda_w = sda_m ? 1'bz : 1'b0;

   always #5 clk = ~clk;

   i2c_counter_slave dut (
      .CLCK      (clk),
      .RST       (rst),
      .SCL       (scl),
      .SDA       (sda_w),
      .CNTR      (cntr),
      .CMD       (cmd),
      .CMD_VALID (cmd_valid),
      .TEND      (tend),
      .BUSY      (busy)
   );

   always @(negedge clk) begin
      if (cmd_valid === 1'b1) cv_cnt++;
      if (tend === 1'b1) tend_cnt++;
   end

   task automatic wait_q();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One SCL bit: present b, sample the bus in the middle of SCL high.
   task automatic bit_xfer(input logic b, output logic r);
      sda_m = b;
      wait_q();
      scl = 1'b1;
      wait_q();
      r = sda_w;
      wait_q();
      scl = 1'b0;
      wait_q();
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_q();
      scl = 1'b1;
      wait_q();
      sda_m = 1'b0;
      wait_q();
      scl = 1'b0;
      wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wait_q();
      scl = 1'b1;
      wait_q();
      sda_m = 1'b1;
      wait_q();
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, input logic exp_ack_bit, input string tag);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
      bit_xfer(1'b1, r);
      check(tag, 32'(r), 32'(exp_ack_bit));
   endtask

   task automatic read_byte(input logic nack, input string tag);
      logic [7:0] d;
      logic [7:0] e;
      logic       r;
      d = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         d[i] = r;
      end
      bit_xfer(nack, r);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s scoreboard empty observed=%0h expected=none", tag, d);
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(d), 32'(e));
      end
   endtask

   initial begin
      int         base_t;
      int         base_cv;
      logic [8:0] idle_bits;
      logic       r;
      logic [7:0] t1_bytes [8];

      t1_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

      rst   = 1'b1;
      scl   = 1'b1;
      sda_m = 1'b1;
      cntr  = {16'h7788, 16'h5566, 16'h3344, 16'h1122};
      repeat (4) @(posedge clk);
      #1;
      check("rst_cmd",       32'(cmd), 32'h00);
      check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
      check("rst_tend",      32'(tend), 32'h0);
      check("rst_busy",      32'(busy), 32'h0);
      check("rst_sda",       32'(sda_w), 32'h1);
      rst = 1'b0;
      wait_q();

      // Full 8-byte read from pointer 0
      base_t = tend_cnt;
      i2c_start();
      write_byte(8'hE5, 1'b0, "t1_addr_ack");
      check("t1_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(t1_bytes[i]);
         read_byte(i == 7, "t1_rd");
      end
      i2c_stop();
      check("t1_tend", 32'(tend_cnt - base_t), 32'd1);
      check("t1_busy_after", 32'(busy), 32'h0);

      // Write pointer 5, repeated START, read two bytes
      base_t  = tend_cnt;
      base_cv = cv_cnt;
      i2c_start();
      write_byte(8'hE4, 1'b0, "t2_waddr_ack");
      write_byte(8'h05, 1'b0, "t2_cmd_ack");
      check("t2_cmd", 32'(cmd), 32'h05);
      check("t2_cv_pulse", 32'(cv_cnt - base_cv), 32'd1);
      i2c_start();
      write_byte(8'hE5, 1'b0, "t2_raddr_ack");
      exp_q.push_back(8'h66);
      read_byte(1'b0, "t2_rd0");
      exp_q.push_back(8'h77);
      read_byte(1'b1, "t2_rd1");
      i2c_stop();
      check("t2_tend", 32'(tend_cnt - base_t), 32'd1);
      check("t2_cv_single", 32'(cv_cnt - base_cv), 32'd1);

      // Pointer 7 wraps to 0; out-of-range write resets the pointer
      i2c_start();
      write_byte(8'hE5, 1'b0, "t3_addr_ack");
      exp_q.push_back(8'h88);
      read_byte(1'b0, "t3_rd_p7");
      exp_q.push_back(8'h11);
      read_byte(1'b0, "t3_rd_wrap");
      exp_q.push_back(8'h22);
      read_byte(1'b1, "t3_rd_p1");
      i2c_stop();
      i2c_start();
      write_byte(8'hE4, 1'b0, "t3_waddr_ack");
      write_byte(8'h0C, 1'b0, "t3_cmd_ack");
      i2c_stop();
      check("t3_cmd", 32'(cmd), 32'h0C);
      i2c_start();
      write_byte(8'hE5, 1'b0, "t3_raddr_ack");
      exp_q.push_back(8'h11);
      read_byte(1'b1, "t3_rd_ptr0");
      i2c_stop();

      // Address mismatch: never driven, no TEND, CMD kept
      base_t  = tend_cnt;
      base_cv = cv_cnt;
      i2c_start();
      write_byte(8'hA0, 1'b1, "t4_addr_nack");
      check("t4_busy_mid", 32'(busy), 32'h0);
      idle_bits = 9'h000;
      for (int i = 8; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         idle_bits[i] = r;
      end
      check("t4_sda_released", 32'(idle_bits), 32'h1FF);
      i2c_stop();
      check("t4_no_tend", 32'(tend_cnt - base_t), 32'd0);
      check("t4_cmd_kept", 32'(cmd), 32'h0C);
      check("t4_no_cv", 32'(cv_cnt - base_cv), 32'd0);

      // Snapshot is atomic across a CNTR change
      i2c_start();
      write_byte(8'hE4, 1'b0, "t5_waddr_ack");
      write_byte(8'h00, 1'b0, "t5_cmd_ack");
      i2c_start();
      write_byte(8'hE5, 1'b0, "t5_raddr_ack");
      exp_q.push_back(8'h11);
      read_byte(1'b0, "t5_rd0");
      cntr[15:0] = 16'hBEEF;
      exp_q.push_back(8'h22);
      read_byte(1'b1, "t5_rd1_old");
      i2c_stop();
      i2c_start();
      write_byte(8'hE4, 1'b0, "t5_waddr2_ack");
      write_byte(8'h00, 1'b0, "t5_cmd2_ack");
      i2c_start();
      write_byte(8'hE5, 1'b0, "t5_raddr2_ack");
      exp_q.push_back(8'hBE);
      read_byte(1'b0, "t5_rd_new0");
      exp_q.push_back(8'hEF);
      read_byte(1'b1, "t5_rd_new1");
      i2c_stop();

      // Reset while the slave holds SDA low (MSB of 0x33 at pointer 2)
      i2c_start();
      write_byte(8'hE5, 1'b0, "t6_addr_ack");
      check("t6_sda_driven", 32'(sda_w), 32'h0);
      #2;
      rst = 1'b1;
      #1;
      check("t6_sda_async", 32'(sda_w), 32'h1);
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_cmd", 32'(cmd), 32'h00);
      check("t6_cmd_valid", 32'(cmd_valid), 32'h0);
      check("t6_tend", 32'(tend), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_q();
      base_t = tend_cnt;
      i2c_start();
      write_byte(8'hE5, 1'b0, "t6_raddr_ack");
      exp_q.push_back(8'hBE);
      read_byte(1'b0, "t6_rd0");
      exp_q.push_back(8'hEF);
      read_byte(1'b1, "t6_rd1");
      i2c_stop();
      check("t6_tend_after", 32'(tend_cnt - base_t), 32'd1);
      check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_counter_slave.md
Name: i2c_counter_slave

Overview:
- Parametrised I2C slave that gives a bus master read access to NUM_CH quadrature-counter values of CNT_WIDTH bits each, and write access to a command/pointer byte.
- Successor to the fixed 4×16-bit counter slave. Adds:
  - a fully synchronous datapath with reset,
  - a register pointer with auto-increment and wrap,
  - repeated-START support,
  - NACK-terminated reads,
  - an atomic counter snapshot.
- Sits between the quadrature decoders and the board I2C bus.

Parameters:
- SLAVE_ADDR, 7'b1110010, 7-bit device address.
- NUM_CH, 4, number of counter channels (1..16).
- CNT_WIDTH, 16, bits per counter; multiple of 8, 8..32.
- NUM_BYTES (derived, not overridable), NUM_CH*CNT_WIDTH/8, readable byte count.
- PTR_W (derived), clog2(NUM_BYTES), pointer width (minimum 1).

Ports:
- CLCK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous, active-high reset.
- SCL  input  1  I2C clock from the bus; asynchronous.
- SDA  inout  1  I2C data; the block only drives 0 or z.
- CNTR  input  NUM_CH*CNT_WIDTH  flattened counters; channel 0 in the LSBs.
- CMD  output  8  last command byte written by the master.
- CMD_VALID  output  1  one-CLCK pulse when CMD updates.
- TEND  output  1  one-CLCK pulse on STOP ending an addressed transaction.
- BUSY  output  1  high from address-match ACK until STOP.

Behaviour:
- Reset
  - Asynchronous: SDA released (z) immediately, including mid-transfer.
  - State=IDLE, pointer=0, snapshot=0, CMD=0, CMD_VALID=0, TEND=0, BUSY=0.
- Synchronisers and bus-condition detection
  - SCL and SDA each pass through a 2-flop synchroniser plus one history flop.
  - SCL edges are detected from the history pair (rise/fall).
  - START = synced SDA 1→0 while synced SCL=1.
  - STOP = synced SDA 0→1 while synced SCL=1.
  - A START in any state, including a repeated START, goes to ADDR with bit counter=0.
  - A STOP in any state goes to IDLE and releases SDA.
  - START/STOP take priority over an SCL edge in the same cycle.
- Sampling and drive timing
  - Data is sampled on SCL rise.
  - SDA is updated on the CLCK cycle after SCL fall is detected.
  - The driven value is held until the next SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - ADDR: shift in 8 bits, MSB first.
    - On the 8th SCL rise, compare bits[7:1] with SLAVE_ADDR and latch R/W = bit 0.
    - Match → ADDR_ACK; mismatch → IGNORE.
  - ADDR_ACK: drive SDA=0 for the ACK bit and assert BUSY.
    - If R/W=1, load the snapshot from CNTR on the SCL fall that starts the ACK bit.
    - Next state is RD_DATA if R/W=1, otherwise WR_DATA.
  - WR_DATA: shift in 8 bits, then go to WR_ACK.
    - The first data byte after each address sets CMD and pulses CMD_VALID, one cycle after the 8th SCL rise.
    - That byte also sets pointer = byte if byte < NUM_BYTES, else pointer = 0.
    - Later bytes in the same write are ACKed and discarded.
  - WR_ACK: drive SDA=0 for one bit, then return to WR_DATA.
  - RD_DATA: send snapshot byte[pointer], MSB first.
    - Byte order: byte 0 is the MSB byte of channel 0, so each channel is sent big-endian, channel 0 first.
    - After the 8th bit, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's ACK on SCL rise.
    - pointer = (pointer+1) mod NUM_BYTES, wrapping to 0.
    - ACK (0) → RD_DATA.
    - NACK (1) → IGNORE, with SDA released; the pointer is still incremented.
  - IGNORE: SDA stays z; exit only on START or STOP.
- Snapshot and pointer persistence
  - The snapshot is stable for the whole read; CNTR changes during the read are not visible.
  - A new snapshot is taken only at the next matched read-address ACK.
  - The pointer persists across transactions; it is changed only by a write or by RST.
- Outputs on STOP
  - TEND pulses one cycle after STOP detection only if BUSY was high; BUSY then clears in the same cycle.
  - Glitch, unaddressed or mismatch transactions produce no TEND.
- Clock-rate requirement: CLCK ≥ 16× SCL. No clock stretching.

Test Plan:
- Reset, then CNTR = {16'h7788, 16'h5566, 16'h3344, 16'h1122}; master reads 8 bytes from 0xE5, ACKing all but the last → bytes 11 22 33 44 55 66 77 88; TEND pulses once at STOP; BUSY low afterwards.
- Write 0xE4, 0x05; repeated START; read 0xE5 for 2 bytes → CMD=0x05 with a single CMD_VALID pulse; read bytes 66 77; pointer ends at 7.
- With pointer=7, read 3 bytes → 88 11 22 (wrap to 0); a write of 0x0C sets pointer=0 and CMD=0x0C.
- Address 0xA0 (mismatch) → NACK (SDA z at the 9th clock); no SDA drive until STOP; no TEND; CMD unchanged.
- CNTR channel 0 changes from 0x1122 to 0xBEEF between byte 0 and byte 1 of a read → bytes are still 11 22; the next read returns BE EF.
- RST asserted while the slave drives SDA=0 (ACK or data) → SDA z immediately; all outputs return to reset values; the next START followed by a read works normally from pointer 0.
